// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - shared types and constants for the LC-3 sequencing controller
// Contents: FSM state enum, execute-stage opcode classes, LC-3 opcode values,
// and the mem_state encodings presented to the memory interface.
package lc3_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_IND,
        S_MEM_RD,
        S_MEM_WR,
        S_WB
    } state_t;

    // Where EXEC hands off to; CLS_NOP covers BR, JMP and unused opcodes,
    // all of which return straight to FETCH.
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_WB,
        CLS_RD,
        CLS_IND,
        CLS_WR
    } op_class_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] MEM_READ     = 2'd0;
    localparam logic [1:0] MEM_IND_READ = 2'd1;
    localparam logic [1:0] MEM_WRITE    = 2'd2;
    localparam logic [1:0] MEM_IDLE     = 2'd3;

endpackage

// File: rtl/lc3_seq_controller_if.sv
// rtl/lc3_seq_controller_if.sv - handshake and control bus between controller and datapath
// Signals: complete_instr/complete_data memory strobes, IR_Exec and psr from the
// datapath, cnt_load/cnt_load_value to preset the retire counter, and the stage
// enables, PC strobes, mem_state, instr_count and timeout_err from the controller.
// Modports: master = controller side, slave = datapath/memory side.
interface lc3_seq_controller_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR_Exec;
    logic [2:0]  psr;
    logic        cnt_load;
    logic [15:0] cnt_load_value;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic [15:0] instr_count;
    logic        timeout_err;

    modport master (
        input  complete_instr, complete_data, IR_Exec, psr, cnt_load, cnt_load_value,
        output enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, br_taken, mem_state, instr_count, timeout_err
    );

    modport slave (
        output complete_instr, complete_data, IR_Exec, psr, cnt_load, cnt_load_value,
        input  enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, br_taken, mem_state, instr_count, timeout_err
    );
endinterface

// File: rtl/lc3_ctrl_decode.sv
// rtl/lc3_ctrl_decode.sv - combinational opcode classification and branch evaluation
// Ports: ir (instruction in execute), psr (N,Z,P flags) in;
// op_class (EXEC successor class), is_ldi, br_taken out.
module lc3_ctrl_decode
    import lc3_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [2:0]  psr,
    output op_class_t   op_class,
    output logic        is_ldi,
    output logic        br_taken
);

    logic [3:0] opcode;
    logic [2:0] nzp;
    logic       unused_ir_bits;

    assign opcode         = ir[15:12];
    assign nzp            = ir[11:9];
    assign unused_ir_bits = ^ir[8:0];

    always_comb begin
        op_class = CLS_NOP;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: op_class = CLS_WB;
            OP_LD, OP_LDR:                  op_class = CLS_RD;
            OP_LDI, OP_STI:                 op_class = CLS_IND;
            OP_ST, OP_STR:                  op_class = CLS_WR;
            default:                        op_class = CLS_NOP;
        endcase
    end

    assign is_ldi   = (opcode == OP_LDI);
    assign br_taken = (opcode == OP_JMP) || ((opcode == OP_BR) && |(nzp & psr));

endmodule

// File: rtl/lc3_seq_controller.sv
// rtl/lc3_seq_controller.sv - LC-3 multi-cycle sequencing FSM with retire counter and handshake timeout
// Ports: clock, reset (async, active-high); bus (master modport): memory completion
// strobes, IR_Exec, psr and counter preset in; stage enables, enable_updatePC,
// br_taken, mem_state, instr_count and sticky timeout_err out.
module lc3_seq_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_seq_controller_if.master bus
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic [15:0]       count_q;
    logic              timeout_q;
    logic              ind_is_ldi;
    logic              retire;
    logic              in_wait;
    logic              hit_limit;
    op_class_t         exec_class;
    logic              exec_ldi;
    logic              exec_br;

    lc3_ctrl_decode u_decode (
        .ir       (bus.IR_Exec),
        .psr      (bus.psr),
        .op_class (exec_class),
        .is_ldi   (exec_ldi),
        .br_taken (exec_br)
    );

    always_comb begin
        state_next           = state;
        retire               = 1'b0;
        bus.enable_fetch     = 1'b0;
        bus.enable_decode    = 1'b0;
        bus.enable_execute   = 1'b0;
        bus.enable_writeback = 1'b0;
        bus.enable_updatePC  = 1'b0;
        bus.br_taken         = 1'b0;
        bus.mem_state        = MEM_IDLE;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                bus.enable_fetch = 1'b1;
                if (bus.complete_instr) begin
                    state_next          = S_DECODE;
                    bus.enable_updatePC = 1'b1;
                end
            end
            S_DECODE: begin
                bus.enable_decode = 1'b1;
                state_next        = S_EXEC;
            end
            S_EXEC: begin
                bus.enable_execute  = 1'b1;
                bus.br_taken        = exec_br;
                bus.enable_updatePC = exec_br;
                case (exec_class)
                    CLS_WB:  state_next = S_WB;
                    CLS_RD:  state_next = S_MEM_RD;
                    CLS_IND: state_next = S_MEM_IND;
                    CLS_WR:  state_next = S_MEM_WR;
                    default: begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            S_MEM_IND: begin
                bus.mem_state = MEM_IND_READ;
                if (bus.complete_data) state_next = ind_is_ldi ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.mem_state = MEM_READ;
                if (bus.complete_data) state_next = S_WB;
            end
            S_MEM_WR: begin
                bus.mem_state = MEM_WRITE;
                if (bus.complete_data) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_WB: begin
                bus.enable_writeback = 1'b1;
                state_next           = S_FETCH;
                retire               = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // wait_cnt holds the number of cycles already spent in the current wait
    // state, so the cycle in which it equals TIMEOUT_CYCLES-1 is the
    // TIMEOUT_CYCLES-th one; the flag is raised on that edge even if the
    // completion strobe arrives in the same cycle.
    assign in_wait   = (state == S_FETCH) || (state == S_MEM_IND) ||
                       (state == S_MEM_RD) || (state == S_MEM_WR);
    assign hit_limit = in_wait && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (state_next != state)
            wait_cnt_next = '0;
        else if (in_wait && (wait_cnt != WAIT_W'(TIMEOUT_CYCLES)))
            wait_cnt_next = wait_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            count_q    <= 16'h0000;
            timeout_q  <= 1'b0;
            ind_is_ldi <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (hit_limit)
                timeout_q <= 1'b1;
            if (bus.cnt_load)
                count_q <= bus.cnt_load_value;
            else if (retire)
                count_q <= count_q + 16'h0001;
            // IR_Exec may move on once EXEC is done; MEM_IND needs the opcode.
            if (state == S_EXEC)
                ind_is_ldi <= exec_ldi;
        end
    end

    assign bus.instr_count = count_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_lc3_seq_controller.sv
// tb/tb_lc3_seq_controller.sv - self-checking bench for lc3_seq_controller
module tb_lc3_seq_controller;

    localparam int TO = 255;

    logic clock;
    logic reset;

    lc3_seq_controller_if bus();

    lc3_seq_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ci;
        logic        cd;
        logic [15:0] ir;
        logic [7:0]  outs;
        logic        err;
    } cyc_t;

    cyc_t        trace[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt_model = 16'h0000;
    logic        err_model = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mk(input logic [3:0] en, input logic upd, input logic br,
                                      input logic [1:0] mem);
        return {en, upd, br, mem};
    endfunction

    function automatic logic [7:0] dut_outs();
        return {bus.enable_fetch, bus.enable_decode, bus.enable_execute, bus.enable_writeback,
                bus.enable_updatePC, bus.br_taken, bus.mem_state};
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push_one(input logic [7:0] outs, input logic [15:0] ir);
        cyc_t c;
        c.ci = rnd_bit(); c.cd = rnd_bit(); c.ir = ir; c.outs = outs; c.err = err_model;
        trace.push_back(c);
    endtask

    // n wait cycles with the strobe low, then one with it high; the stray
    // strobe of the other memory port is randomised since it must be ignored.
    task automatic add_wait(input logic [7:0] wait_outs, input logic [7:0] done_outs,
                            input int n, input bit is_fetch, input logic [15:0] ir);
        cyc_t c;
        for (int i = 0; i <= n; i++) begin
            c.ci   = is_fetch ? (i == n) : rnd_bit();
            c.cd   = is_fetch ? rnd_bit() : (i == n);
            c.ir   = ir;
            c.outs = (i == n) ? done_outs : wait_outs;
            c.err  = err_model;
            trace.push_back(c);
            if (i + 1 == TO) err_model = 1'b1;
        end
    endtask

    // One instruction from its first FETCH cycle to its last cycle before the
    // next FETCH. stop_at >= 0 plays only that many cycles (abandoned instruction).
    task automatic run_instr(input logic [15:0] ir, input logic [2:0] psr_v, input int fw,
                             input int w1, input int w2, input int stop_at);
        logic [3:0]  op;
        logic [15:0] ir_late;
        logic        br;
        op      = ir[15:12];
        ir_late = 16'($urandom);
        trace.delete();
        add_wait(mk(4'b1000, 0, 0, 3), mk(4'b1000, 1, 0, 3), fw, 1'b1, ir);
        push_one(mk(4'b0100, 0, 0, 3), ir);
        br = (op == 4'b1100) || ((op == 4'b0000) && ((ir[11:9] & psr_v) != 3'b000));
        push_one(mk(4'b0010, br, br, 3), ir);
        case (op)
            4'b0001, 4'b0101, 4'b1001, 4'b1110: push_one(mk(4'b0001, 0, 0, 3), ir_late);
            4'b0010, 4'b0110: begin
                add_wait(mk(0, 0, 0, 0), mk(0, 0, 0, 0), w1, 1'b0, ir_late);
                push_one(mk(4'b0001, 0, 0, 3), ir_late);
            end
            4'b1010: begin
                add_wait(mk(0, 0, 0, 1), mk(0, 0, 0, 1), w1, 1'b0, ir_late);
                add_wait(mk(0, 0, 0, 0), mk(0, 0, 0, 0), w2, 1'b0, ir_late);
                push_one(mk(4'b0001, 0, 0, 3), ir_late);
            end
            4'b1011: begin
                add_wait(mk(0, 0, 0, 1), mk(0, 0, 0, 1), w1, 1'b0, ir_late);
                add_wait(mk(0, 0, 0, 2), mk(0, 0, 0, 2), w2, 1'b0, ir_late);
            end
            4'b0011, 4'b0111: add_wait(mk(0, 0, 0, 2), mk(0, 0, 0, 2), w1, 1'b0, ir_late);
            default: ;
        endcase
        for (int k = 0; k < trace.size(); k++) begin
            if (stop_at >= 0 && k >= stop_at) break;
            @(posedge clock);
            #1;
            bus.complete_instr = trace[k].ci;
            bus.complete_data  = trace[k].cd;
            bus.IR_Exec        = trace[k].ir;
            bus.psr            = psr_v;
            bus.cnt_load       = 1'b0;
            @(negedge clock);
            check($sformatf("outs op%0h cyc%0d", op, k), 32'(dut_outs()), 32'(trace[k].outs));
            check($sformatf("count op%0h cyc%0d", op, k), 32'(bus.instr_count), 32'(cnt_model));
            check($sformatf("timeout op%0h cyc%0d", op, k), 32'(bus.timeout_err), 32'(trace[k].err));
        end
        if (stop_at < 0) cnt_model = cnt_model + 16'h0001;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.complete_instr = 1'b0;
        bus.complete_data  = 1'b0;
        bus.IR_Exec        = 16'h0000;
        bus.psr            = 3'b000;
        bus.cnt_load       = 1'b0;
        bus.cnt_load_value = 16'h0000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_outs", 32'(dut_outs()), 32'h03);
        check("rst_count", 32'(bus.instr_count), 32'h0);
        check("rst_timeout", 32'(bus.timeout_err), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("idle_outs", 32'(dut_outs()), 32'h03);
        check("idle_count", 32'(bus.instr_count), 32'h0);
        cnt_model = 16'h0000;
        err_model = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        do_reset();

        // Three FETCH cycles then ADD through WB.
        run_instr(16'h1042, 3'b000, 2, 0, 0, -1);
        // LDI with two cycles in each memory state.
        run_instr(16'hA205, 3'b001, 0, 1, 1, -1);
        // BR n: not taken with Z, taken with N.
        run_instr(16'h0803, 3'b010, 0, 0, 0, -1);
        run_instr(16'h0803, 3'b100, 1, 0, 0, -1);

        for (int n = 0; n < 80; n++)
            run_instr(16'($urandom), 3'($urandom), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4), -1);

        // STR with data withheld 255 cycles, then the flag must stick.
        run_instr(16'h7000 | 16'($urandom_range(0, 4095)), 3'b000, 0, TO, 0, -1);
        for (int n = 0; n < 4; n++)
            run_instr(16'($urandom), 3'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), -1);

        // Reset while an LD is waiting in MEM_RD takes effect without a clock edge.
        run_instr(16'h2000 | 16'($urandom_range(0, 4095)), 3'b000, 0, 5, 0, 5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_outs", 32'(dut_outs()), 32'h03);
        check("async_rst_count", 32'(bus.instr_count), 32'h0);
        check("async_rst_timeout", 32'(bus.timeout_err), 32'h0);
        do_reset();

        // Fetch waits just under and exactly at the limit, strobe on the last cycle.
        run_instr(16'h1000 | 16'($urandom_range(0, 4095)), 3'b000, TO - 2, 0, 0, -1);
        run_instr(16'h5000 | 16'($urandom_range(0, 4095)), 3'b000, TO - 1, 0, 0, -1);
        run_instr(16'($urandom), 3'($urandom), 1, 1, 1, -1);

        // Counter preset to 0xFFFF, one retire wraps it.
        do_reset();
        bus.cnt_load       = 1'b1;
        bus.cnt_load_value = 16'hFFFF;
        cnt_model          = 16'hFFFF;
        run_instr(16'h1042, 3'b000, 0, 0, 0, -1);
        @(posedge clock);
        #1 bus.complete_instr = 1'b0;
        @(negedge clock);
        check("wrap_count", 32'(bus.instr_count), 32'h0000);
        check("wrap_fetch", 32'(dut_outs()), 32'(mk(4'b1000, 0, 0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
